data_bus_arbiter: RTL and testbench
===================================

// Module: data_bus_arbiter
// PURPOSE
//  Parametrised, registered LC-3 CPU data-bus driver: NSRC gated sources (MDR, ALU, PC, MARMUX, ...)
//  onto one WIDTH-bit bus, selected by a one-hot gate vector from the control FSM.
//  Adds hold-last-value, fixed-priority contention resolution, a contention monitor and bus-ownership state.
//  Sits between the datapath gate outputs and every bus consumer (MAR, MDR, IR, regfile, PC).
// PARAMETERS
//  WIDTH      16  bus width in bits
//  NSRC       4   number of gated sources; >=2
//  HOLD_LAST  1   1: no gate -> bus holds last driven value; 0: no gate -> default_val
//  REG_OUT    1   1: bus_out registered (1-cycle latency); 0: bus_out combinational, status still registered
// PORTS
//  Clk                input  1             system clock, rising edge
//  Reset_n            input  1             asynchronous, active-low reset
//  src_data           input  NSRC*WIDTH    source i occupies bits [i*WIDTH +: WIDTH]
//  gate               input  NSRC          one-hot gate enables; bit i = source i
//  default_val        input  WIDTH         undriven-bus value when HOLD_LAST=0
//  clr_err            input  1             clears contention_sticky and contention_cnt
//  bus_out            output WIDTH         bus value
//  bus_valid          output 1             1 when bus_out reflects an actively gated source
//  owner_idx          output $clog2(NSRC)  index of the winning source (last owner while idle)
//  handover           output 1             1-cycle pulse: owner changed between back-to-back driven cycles
//  contention         output 1             1-cycle pulse: >1 gate bit set
//  contention_sticky  output 1             set on any contention, held until clr_err
//  contention_cnt     output 8             contention event count, saturates at 255
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert): bus_out=0, last_val=0, bus_valid=0, owner_idx=0,
//   handover=0, contention=0, contention_sticky=0, contention_cnt=0, state=IDLE.
//  Selection, per cycle, from popcount(gate):
//   ==0: sel = HOLD_LAST ? last_val : default_val; valid=0; owner_idx unchanged.
//   ==1: sel = src_data[idx]; valid=1; owner_idx=idx.
//   >1 : lowest set index wins; sel = that source; valid=1; contention pulse.
//  last_val <= sel whenever popcount>=1 (never updated while idle).
//  REG_OUT=1: bus_out/bus_valid/owner_idx registered, updated at the edge after gate; latency 1.
//  REG_OUT=0: bus_out/bus_valid/owner_idx combinational from gate/src_data; status flags registered.
//  contention, handover, sticky and cnt are always registered (1-cycle latency).
//  FSM state (bus_state_t):
//   IDLE    -> OWNED on popcount==1; -> CONTEND on popcount>1; else stay
//   OWNED   -> IDLE on 0; -> CONTEND on >1; stay on 1 (handover if idx != owner_idx)
//   CONTEND -> IDLE on 0; -> OWNED on 1; stay on >1
//  handover fires only for OWNED->OWNED or CONTEND->OWNED with a different owner; never out of IDLE.
//  contention_cnt +1 per contended cycle (not per episode); saturates at 8'hFF, no wrap.
//  clr_err with a contended cycle in the same cycle: event wins -> sticky=1, cnt=1.
//  clr_err has no effect on bus_out, last_val, owner_idx or state.
//  Reset mid-drive: all state clears immediately; first cycle after release behaves as from IDLE.
// STRUCTURE
//  lc3_bus_pkg: bus_state_t {IDLE, OWNED, CONTEND}; SRC_MDR=0, SRC_ALU=1, SRC_PC=2, SRC_MARMUX=3;
//   CNT_W=8.
//  Sub-module onehot_prio_enc #(N): gate -> lowest index, any, multi (popcount>1); purely combinational.
//  Top: unpack mux, FSM, last_val/output registers, monitor counters.
// TESTING
//  1 gate=4'b0010, ALU=16'h1234 -> next cycle bus_out=16'h1234, valid=1, owner_idx=1, no contention.
//  2 Drive PC=16'h3000, then gate=0 for 3 cycles (HOLD_LAST=1) -> bus_out stays 16'h3000, valid=0;
//    with HOLD_LAST=0, default_val=16'hDEAD -> bus_out=16'hDEAD.
//  3 gate=4'b1010 (ALU=16'h00AA, MARMUX=16'h5555) -> bus_out=16'h00AA, owner=1, contention pulse,
//    sticky=1, cnt=1; hold 300 cycles -> cnt=255, no wrap.
//  4 gate 4'b0001 then 4'b0100 back-to-back -> handover pulse once; insert idle cycle -> no handover.
//  5 clr_err in same cycle as contention -> sticky=1, cnt=1; clr_err alone -> sticky=0, cnt=0.
//  6 Assert Reset_n=0 mid-drive between edges -> all outputs 0 immediately; REG_OUT=0 build gives
//    zero-latency bus_out.

Source files
------------

// File: rtl/lc3_bus_pkg.sv
// Shared types and constants for the LC-3 data-bus arbiter.
// Source indices follow the datapath gate order used by the control FSM.
package lc3_bus_pkg;
   typedef enum logic [1:0] {IDLE, OWNED, CONTEND} bus_state_t;

   localparam int SRC_MDR    = 0;
   localparam int SRC_ALU    = 1;
   localparam int SRC_PC     = 2;
   localparam int SRC_MARMUX = 3;
   localparam int CNT_W      = 8;
endpackage

// File: rtl/data_bus_arbiter_if.sv
// Bus bundle between the datapath/control side (master) and the arbiter (slave).
// Gate and source data flow in; the resolved bus value and monitor status flow out.
interface data_bus_arbiter_if #(
   parameter int WIDTH = 16,
   parameter int NSRC  = 4
);
   import lc3_bus_pkg::*;
   localparam int IDXW = $clog2(NSRC);

   logic [NSRC*WIDTH-1:0] src_data;
   logic [NSRC-1:0]       gate;
   logic [WIDTH-1:0]      default_val;
   logic                  clr_err;
   logic [WIDTH-1:0]      bus_out;
   logic                  bus_valid;
   logic [IDXW-1:0]       owner_idx;
   logic                  handover;
   logic                  contention;
   logic                  contention_sticky;
   logic [CNT_W-1:0]      contention_cnt;

   modport master (
      output src_data, gate, default_val, clr_err,
      input  bus_out, bus_valid, owner_idx, handover, contention,
             contention_sticky, contention_cnt
   );

   modport slave (
      input  src_data, gate, default_val, clr_err,
      output bus_out, bus_valid, owner_idx, handover, contention,
             contention_sticky, contention_cnt
   );
endinterface

// File: rtl/onehot_prio_enc.sv
// Gate vector -> lowest set index, any-set and more-than-one-set flags.
// Purely combinational, zero latency, no backpressure.
module onehot_prio_enc #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  gate,
   output logic [IW-1:0] idx,
   output logic          any,
   output logic          multi
);
   always_comb begin
      idx = '0;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (gate[i]) idx = IW'(i);
      end
      any   = |gate;
      multi = |(gate & (gate - N'(1)));
   end
endmodule

// File: rtl/data_bus_arbiter.sv
// Gated-source bus driver with hold-last, fixed priority, ownership FSM and contention monitor.
// Latency 1 on bus outputs when REG_OUT=1 (0 otherwise), status always 1; no backpressure.
module data_bus_arbiter
   import lc3_bus_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int NSRC      = 4,
   parameter bit HOLD_LAST = 1'b1,
   parameter bit REG_OUT   = 1'b1
) (
   input logic              Clk,
   input logic              Reset_n,
   data_bus_arbiter_if.slave bus
);
   localparam int IDXW = $clog2(NSRC);

   logic [IDXW-1:0]  idx;
   logic             any;
   logic             multi;
   logic [WIDTH-1:0] sel_val;
   logic [WIDTH-1:0] last_val;
   logic [WIDTH-1:0] bus_q;
   logic             valid_q;
   logic [IDXW-1:0]  owner_q;
   logic             handover_q;
   logic             handover_nxt;
   logic             contention_q;
   logic             sticky_q;
   logic [CNT_W-1:0] cnt_q;
   bus_state_t       state, state_nxt;

   onehot_prio_enc #(.N(NSRC)) u_enc (
      .gate  (bus.gate),
      .idx   (idx),
      .any   (any),
      .multi (multi)
   );

   always_comb begin
      sel_val = bus.default_val;
      if (any)            sel_val = bus.src_data[int'(idx)*WIDTH +: WIDTH];
      else if (HOLD_LAST) sel_val = last_val;
   end

   always_comb begin
      state_nxt    = state;
      handover_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (multi)    state_nxt = CONTEND;
            else if (any) state_nxt = OWNED;
         end
         OWNED, CONTEND: begin
            if (!any)       state_nxt = IDLE;
            else if (multi) state_nxt = CONTEND;
            else begin
               state_nxt    = OWNED;
               handover_nxt = (idx != owner_q);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state        <= IDLE;
         last_val     <= '0;
         bus_q        <= '0;
         valid_q      <= 1'b0;
         owner_q      <= '0;
         handover_q   <= 1'b0;
         contention_q <= 1'b0;
         sticky_q     <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state        <= state_nxt;
         bus_q        <= sel_val;
         valid_q      <= any;
         handover_q   <= handover_nxt;
         contention_q <= multi;
         if (any) begin
            last_val <= sel_val;
            owner_q  <= idx;
         end
         // A contended cycle outranks a simultaneous clear.
         if (multi) begin
            sticky_q <= 1'b1;
            if (bus.clr_err)        cnt_q <= CNT_W'(1);
            else if (cnt_q != '1)   cnt_q <= cnt_q + CNT_W'(1);
         end else if (bus.clr_err) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
         end
      end
   end

   always_comb begin
      bus.bus_out   = bus_q;
      bus.bus_valid = valid_q;
      bus.owner_idx = owner_q;
      if (!REG_OUT) begin
         bus.bus_out   = sel_val;
         bus.bus_valid = any;
         bus.owner_idx = any ? idx : owner_q;
      end
   end

   assign bus.handover          = handover_q;
   assign bus.contention        = contention_q;
   assign bus.contention_sticky = sticky_q;
   assign bus.contention_cnt    = cnt_q;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench: registered/hold-last build driven from a vector table, plus
// hand sequences for saturation, the combinational default-value build and mid-drive reset.
module tb_data_bus_arbiter;
   logic        Clk;
   logic        Reset_n;
   logic [3:0]  gate;
   logic [15:0] mdr, alu, pc, marmux;
   logic        clr_err;
   int          n_chk;
   int          n_fail;

   data_bus_arbiter_if #(.WIDTH(16), .NSRC(4)) ifa ();
   data_bus_arbiter_if #(.WIDTH(16), .NSRC(4)) ifb ();

   assign ifa.src_data    = {marmux, pc, alu, mdr};
   assign ifa.gate        = gate;
   assign ifa.default_val = 16'hDEAD;
   assign ifa.clr_err     = clr_err;
   assign ifb.src_data    = {marmux, pc, alu, mdr};
   assign ifb.gate        = gate;
   assign ifb.default_val = 16'hDEAD;
   assign ifb.clr_err     = clr_err;

   data_bus_arbiter #(.WIDTH(16), .NSRC(4), .HOLD_LAST(1'b1), .REG_OUT(1'b1)) dut_a (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (ifa.slave)
   );

   data_bus_arbiter #(.WIDTH(16), .NSRC(4), .HOLD_LAST(1'b0), .REG_OUT(1'b0)) dut_b (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (ifb.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [3:0]  gate;
      logic [15:0] alu;
      logic        clr;
      logic [15:0] bus;
      logic        vld;
      logic [1:0]  own;
      logic        ho;
      logic        ct;
      logic        st;
      logic [7:0]  cnt;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_a(input string tag, input vec_t v);
      check({tag, " bus_out"},   32'(ifa.bus_out),           32'(v.bus));
      check({tag, " bus_valid"}, 32'(ifa.bus_valid),         32'(v.vld));
      check({tag, " owner_idx"}, 32'(ifa.owner_idx),         32'(v.own));
      check({tag, " handover"},  32'(ifa.handover),          32'(v.ho));
      check({tag, " contention"},32'(ifa.contention),        32'(v.ct));
      check({tag, " sticky"},    32'(ifa.contention_sticky), 32'(v.st));
      check({tag, " cnt"},       32'(ifa.contention_cnt),    32'(v.cnt));
   endtask

   initial begin
      vec_t r;
      n_chk  = 0;
      n_fail = 0;
      //            gate     alu       clr   bus       vld  own   ho   ct   st   cnt
      vecs[0]  = '{4'b0010, 16'h1234, 1'b0, 16'h1234, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[1]  = '{4'b0100, 16'h00AA, 1'b0, 16'h3000, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[2]  = '{4'b0000, 16'h00AA, 1'b0, 16'h3000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[3]  = '{4'b0000, 16'h00AA, 1'b0, 16'h3000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[4]  = '{4'b0000, 16'h00AA, 1'b0, 16'h3000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[5]  = '{4'b1010, 16'h00AA, 1'b0, 16'h00AA, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 8'd1};
      vecs[6]  = '{4'b0000, 16'h00AA, 1'b0, 16'h00AA, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 8'd1};
      vecs[7]  = '{4'b0001, 16'h00AA, 1'b0, 16'h1111, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 8'd1};
      vecs[8]  = '{4'b0100, 16'h00AA, 1'b0, 16'h3000, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 8'd1};
      vecs[9]  = '{4'b0000, 16'h00AA, 1'b0, 16'h3000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 8'd1};
      vecs[10] = '{4'b0001, 16'h00AA, 1'b0, 16'h1111, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 8'd1};
      vecs[11] = '{4'b1100, 16'h00AA, 1'b0, 16'h3000, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 8'd2};
      vecs[12] = '{4'b1010, 16'h00AA, 1'b1, 16'h00AA, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 8'd1};
      vecs[13] = '{4'b1000, 16'h00AA, 1'b0, 16'h5555, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 8'd1};
      vecs[14] = '{4'b0000, 16'h00AA, 1'b1, 16'h5555, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[15] = '{4'b1000, 16'h00AA, 1'b0, 16'h5555, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[16] = '{4'b1000, 16'h00AA, 1'b0, 16'h5555, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'd0};

      Reset_n = 1'b0;
      gate    = 4'b0000;
      clr_err = 1'b0;
      mdr     = 16'h1111;
      alu     = 16'h00AA;
      pc      = 16'h3000;
      marmux  = 16'h5555;

      repeat (2) @(negedge Clk);
      r = '{4'b0000, 16'h0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
      check_a("reset", r);
      Reset_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         gate    = vecs[i].gate;
         alu     = vecs[i].alu;
         clr_err = vecs[i].clr;
         @(posedge Clk);
         #1;
         check_a($sformatf("vec%0d", i), vecs[i]);
         @(negedge Clk);
      end

      // Long contention: counter climbs one per cycle and pins at 255.
      gate    = 4'b1010;
      clr_err = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge Clk);
         #1;
         if (i == 0) check("sat first cnt", 32'(ifa.contention_cnt), 32'd1);
      end
      check("sat cnt",        32'(ifa.contention_cnt),    32'd255);
      check("sat sticky",     32'(ifa.contention_sticky), 32'd1);
      check("sat contention", 32'(ifa.contention),        32'd1);
      check("sat bus_out",    32'(ifa.bus_out),           32'h00AA);
      @(negedge Clk);
      gate    = 4'b0000;
      clr_err = 1'b1;
      @(posedge Clk);
      #1;
      check("clr cnt",        32'(ifa.contention_cnt),    32'd0);
      check("clr sticky",     32'(ifa.contention_sticky), 32'd0);
      check("clr bus_out",    32'(ifa.bus_out),           32'h00AA);
      check("clr owner",      32'(ifa.owner_idx),         32'd1);
      @(negedge Clk);
      clr_err = 1'b0;

      // Combinational build: zero-latency selection and default value when idle.
      gate = 4'b0100;
      #1;
      check("comb bus_out",   32'(ifb.bus_out),   32'h3000);
      check("comb valid",     32'(ifb.bus_valid), 32'd1);
      check("comb owner",     32'(ifb.owner_idx), 32'd2);
      @(negedge Clk);
      gate = 4'b0000;
      #1;
      check("comb idle bus",   32'(ifb.bus_out),   32'hDEAD);
      check("comb idle valid", 32'(ifb.bus_valid), 32'd0);
      check("comb idle owner", 32'(ifb.owner_idx), 32'd2);
      check("hold idle bus",   32'(ifa.bus_out),   32'h3000);
      @(negedge Clk);

      // Reset asserted between edges while driving with contention state set.
      gate = 4'b1010;
      @(negedge Clk);
      check("pre-rst sticky", 32'(ifa.contention_sticky), 32'd1);
      #2;
      Reset_n = 1'b0;
      #1;
      r = '{4'b0000, 16'h0, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0};
      check_a("midrst", r);
      @(negedge Clk);
      gate    = 4'b0100;
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;
      check("post-rst bus_out",  32'(ifa.bus_out),   32'h3000);
      check("post-rst valid",    32'(ifa.bus_valid), 32'd1);
      check("post-rst owner",    32'(ifa.owner_idx), 32'd2);
      check("post-rst handover", 32'(ifa.handover),  32'd0);
      @(negedge Clk);
      gate = 4'b0000;
      @(negedge Clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
